// File: rtl/clk_div_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : clk_div_seq_pkg                                                    |
// | Desc   : Shared state encoding, default sizes and entry field offsets.      |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
package clk_div_seq_pkg;

  localparam int unsigned DEFAULT_DEPTH = 8;
  localparam int unsigned DEFAULT_AW    = 3;
  localparam int unsigned DEFAULT_IW    = 8;
  localparam int unsigned DEFAULT_LW    = 8;

  // Entry word is {index, duration}; duration occupies the low bits.
  localparam int unsigned DUR_LSB = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/clk_div_seq_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : clk_div_seq_table                                                  |
// | Desc   : DEPTH x W step table, one synchronous write port, async read.      |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module clk_div_seq_table #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned W     = 16
) (
  input  logic          i_clkPin,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  // Contents are deliberately left unreset; the table is always programmed before use.
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clkPin) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/clk_div_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : clk_div_sequencer                                                  |
// | Desc   : Plays a table of (index, duration) steps into clk_divider, timing  |
// |          each step in divided-clock rising edges. Option: CLK_DIV_SEQ_LOOP_EN|
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module clk_div_sequencer
  import clk_div_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = DEFAULT_AW,
  parameter int unsigned IW    = DEFAULT_IW,
  parameter int unsigned LW    = DEFAULT_LW
) (
  input  logic             i_clkPin,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [IW+LW-1:0] i_wr_data,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_loop,
  input  logic             i_div_clk,
  output logic [IW-1:0]    o_indexSelectLine,
  output logic             o_div_ena,
  output logic             o_busy,
  output logic [AW-1:0]    o_step,
  output logic             o_done,
  output logic             o_wr_err
);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic             r_div_q;
  logic [LW-1:0]    r_cnt;
  logic [AW-1:0]    r_step;
  logic [IW-1:0]    r_idx;
  logic             r_ena;
  logic             r_wr_err;
  logic             w_busy;
  logic             w_done;
  logic             w_rise;
  logic             w_loop;
  logic             w_last;
  logic             w_entry_end;
  logic [IW+LW-1:0] w_entry;
  logic [LW-1:0]    w_dur;
  logic [IW-1:0]    w_idx;

`ifdef CLK_DIV_SEQ_LOOP_EN
  assign w_loop = i_loop;
`else
  logic w_unused_loop;
  assign w_unused_loop = i_loop;
  assign w_loop        = 1'b0;
`endif

  clk_div_seq_table #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (IW + LW)
  ) u_table (
    .i_clkPin  (i_clkPin),
    .i_wr_en   (i_wr_en & ~w_busy),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (r_step),
    .o_rd_data (w_entry)
  );

  assign w_dur       = w_entry[DUR_LSB +: LW];
  assign w_idx       = w_entry[DUR_LSB + LW +: IW];
  assign w_rise      = i_div_clk & ~r_div_q;
  assign w_last      = (r_step == AW'(DEPTH - 1));
  // Duration is never zero in RUN, so dur-1 cannot underflow here.
  assign w_entry_end = w_rise && (r_cnt == (w_dur - LW'(1)));

  always_ff @(posedge i_clkPin or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start && !i_stop) w_next = ST_LOAD;
      ST_LOAD: begin
        if (i_stop)             w_next = ST_IDLE;
        else if (w_dur == '0)   w_next = ST_DONE;
        else                    w_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_stop)                          w_next = ST_IDLE;
        else if (w_entry_end && w_last && !w_loop) w_next = ST_DONE;
        else if (w_entry_end)                w_next = ST_LOAD;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_LOAD, ST_RUN: w_busy = 1'b1;
      ST_DONE:         w_done = 1'b1;
      default:         ;
    endcase
  end

  always_ff @(posedge i_clkPin or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_q  <= 1'b0;
      r_cnt    <= '0;
      r_step   <= '0;
      r_idx    <= '0;
      r_ena    <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_div_q  <= i_div_clk;
      r_wr_err <= i_wr_en & w_busy;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_stop) begin
            r_step <= '0;
            r_cnt  <= '0;
          end
        end
        ST_LOAD: begin
          if (i_stop) begin
            r_ena <= 1'b0;
          end else if (w_dur != '0) begin
            r_idx <= w_idx;
            r_ena <= 1'b1;
            r_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            r_ena <= 1'b0;
          end else if (w_rise) begin
            r_cnt <= r_cnt + LW'(1);
            if (w_entry_end) begin
              if (!w_last)     r_step <= r_step + AW'(1);
              else if (w_loop) r_step <= '0;
            end
          end
        end
        ST_DONE: r_ena <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_indexSelectLine = r_idx;
  assign o_div_ena         = r_ena;
  assign o_busy            = w_busy;
  assign o_step            = r_step;
  assign o_done            = w_done;
  assign o_wr_err          = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_clk_div_sequencer                                               |
// | Desc   : Directed bench with a step-level reference model for the sequencer.|
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module tb_clk_div_sequencer;

`ifdef CLK_DIV_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic        div_clk = 1'b0;
  logic [7:0]  idx;
  logic        ena, busy, done, wr_err;
  logic [2:0]  step;

  int n_vec = 0;
  int n_err = 0;

  clk_div_sequencer dut (
    .i_clkPin          (clk),
    .i_rst_n           (rst_n),
    .i_wr_en           (wr_en),
    .i_wr_addr         (wr_addr),
    .i_wr_data         (wr_data),
    .i_start           (start),
    .i_stop            (stop),
    .i_loop            (loop),
    .i_div_clk         (div_clk),
    .o_indexSelectLine (idx),
    .o_div_ena         (ena),
    .o_busy            (busy),
    .o_step            (step),
    .o_done            (done),
    .o_wr_err          (wr_err)
  );

  always #5 clk = ~clk;

  // Divided clock: one-cycle high pulse every third system clock, changing 2ns after posedge.
  bit div_run = 1'b0;
  int dcnt = 0;
  always @(posedge clk) begin
    #2;
    if (div_run) begin
      dcnt    = (dcnt + 1) % 3;
      div_clk = (dcnt == 0);
    end else begin
      div_clk = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: step pointer plus a count of rises still owed to the current step.
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;
  int          m_mode = M_IDLE;
  int          m_left = 0;
  logic [7:0]  m_idx  = '0;
  logic        m_ena  = 1'b0;
  logic [2:0]  m_step = '0;
  logic        m_err  = 1'b0;
  logic        m_divq = 1'b0;
  logic [15:0] mtab [8];

  initial begin
    bit m_rise, m_busy;
    for (int i = 0; i < 8; i++) mtab[i] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = M_IDLE; m_left = 0; m_idx = '0; m_ena = 1'b0;
        m_step = '0; m_err = 1'b0; m_divq = 1'b0;
      end else begin
        m_rise = div_clk && !m_divq;
        m_divq = div_clk;
        m_busy = (m_mode == M_LOAD) || (m_mode == M_RUN);
        m_err  = wr_en && m_busy;
        if (wr_en && !m_busy) mtab[wr_addr] = wr_data;
        case (m_mode)
          M_IDLE: if (start && !stop) begin m_mode = M_LOAD; m_step = '0; end
          M_LOAD: begin
            if (stop) begin
              m_mode = M_IDLE; m_ena = 1'b0;
            end else if (mtab[m_step][7:0] == 8'd0) begin
              m_mode = M_DONE;
            end else begin
              m_idx  = mtab[m_step][15:8];
              m_left = int'(mtab[m_step][7:0]);
              m_ena  = 1'b1;
              m_mode = M_RUN;
            end
          end
          M_RUN: begin
            if (stop) begin
              m_mode = M_IDLE; m_ena = 1'b0;
            end else if (m_rise) begin
              m_left--;
              if (m_left == 0) begin
                if (m_step != 3'd7) begin m_step = m_step + 3'd1; m_mode = M_LOAD; end
                else if (LOOP_EN && loop) begin m_step = '0; m_mode = M_LOAD; end
                else m_mode = M_DONE;
              end
            end
          end
          default: begin m_ena = 1'b0; m_mode = M_IDLE; end
        endcase
      end
    end
  end

  // Every-cycle compare plus bookkeeping of done pulses and rises seen per index.
  bit   chk_en = 1'b0;
  int   done_cnt = 0;
  int   rises_at [256];
  logic prev_div = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("idx",    {24'd0, idx},    {24'd0, m_idx});
        chk("ena",    {31'd0, ena},    {31'd0, m_ena});
        chk("busy",   {31'd0, busy},   {31'd0, 1'(m_mode == M_LOAD || m_mode == M_RUN)});
        chk("step",   {29'd0, step},   {29'd0, m_step});
        chk("done",   {31'd0, done},   {31'd0, 1'(m_mode == M_DONE)});
        chk("wr_err", {31'd0, wr_err}, {31'd0, m_err});
        if (done) done_cnt++;
        if (div_clk && !prev_div && busy) rises_at[idx]++;
      end
      prev_div = div_clk;
    end
  end

  task automatic clear_rises();
    for (int i = 0; i < 256; i++) rises_at[i] = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] ix, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = {ix, d};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  int d0;

  initial begin
    clear_rises();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_idx",  {24'd0, idx}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    div_run = 1'b1;

    wr(3'd0, 8'h10, 8'd2);
    wr(3'd1, 8'h40, 8'd3);
    wr(3'd2, 8'h00, 8'd0);

    // Asynchronous reset in the middle of a step.
    pulse_start();
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_idx",  {24'd0, idx}, 32'd0);
    chk("arst_ena",  {31'd0, ena}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_step", {29'd0, step}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Two-step sequence ending on the zero-duration marker.
    clear_rises(); d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("first_idx_latency", {24'd0, idx}, 32'h10);
    wait_done(200, "seq2_done_timeout");
    chk("seq2_step_at_done", {29'd0, step}, 32'd2);
    @(negedge clk);
    chk("seq2_ena_off",  {31'd0, ena}, 32'd0);
    chk("seq2_done_cnt", done_cnt - d0, 32'd1);
    chk("seq2_rises_10", rises_at[8'h10], 32'd2);
    chk("seq2_rises_40", rises_at[8'h40], 32'd3);
    chk("seq2_idx_hold", {24'd0, idx}, 32'h40);

    // Start and stop together in IDLE: stop wins.
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("start_stop_idle", {31'd0, busy}, 32'd0);

    // Write and restart attempt while running; both must be ignored.
    clear_rises(); d0 = done_cnt;
    pulse_start();
    repeat (5) @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = {8'h77, 8'd5};
    @(negedge clk); wr_en = 1'b0;
    chk("wr_err_pulse", {31'd0, wr_err}, 32'd1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(200, "wr_run_done_timeout");
    clear_rises();
    pulse_start();
    wait_done(200, "replay_done_timeout");
    chk("replay_rises_10", rises_at[8'h10], 32'd2);
    chk("replay_rises_77", rises_at[8'h77], 32'd0);

    // Stop during RUN: back to IDLE with no done pulse.
    d0 = done_cnt;
    pulse_start();
    repeat (6) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("stop_busy",     {31'd0, busy}, 32'd0);
    chk("stop_no_done",  done_cnt - d0, 32'd0);

    // Full table, one rise per step.
    for (int k = 0; k < 8; k++) wr(3'(k), 8'(8'h80 + k), 8'd1);
    clear_rises(); d0 = done_cnt;
    pulse_start();
    wait_done(300, "full_done_timeout");
    chk("full_step_at_done", {29'd0, step}, 32'd7);
    for (int k = 0; k < 8; k++) chk("full_rise_per_step", rises_at[8'h80 + k], 32'd1);
    @(negedge clk);
    chk("full_done_cnt", done_cnt - d0, 32'd1);

`ifdef CLK_DIV_SEQ_LOOP_EN
    clear_rises(); d0 = done_cnt;
    loop = 1'b1;
    pulse_start();
    repeat (70) @(negedge clk);
    chk("loop_busy", {31'd0, busy}, 32'd1);
    chk("loop_wrapped", {31'd0, 1'(rises_at[8'h80] >= 2)}, 32'd1);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0; loop = 1'b0;
    repeat (3) @(negedge clk);
    chk("loop_stop_busy", {31'd0, busy}, 32'd0);
    chk("loop_no_done", done_cnt - d0, 32'd0);
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
